// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the FPU output stages: class codes, result word
// layout and the IEEE-754 single-precision classifier.
package fpu_pkg;

    localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
    localparam logic [31:0] QNAN_DEFAULT = 32'h7FC00000;

    typedef enum logic [2:0] {
        CLS_ZERO      = 3'd0,
        CLS_SUBNORMAL = 3'd1,
        CLS_NORMAL    = 3'd2,
        CLS_INF       = 3'd3,
        CLS_NAN       = 3'd4
    } fp_class_t;

    typedef struct packed {
        logic [31:0] result;
        logic        error;
        logic        overflow;
        fp_class_t   cls;
    } fp_result_t;

    function automatic fp_class_t fp_classify(input logic [31:0] word);
        logic [7:0]  exp_f;
        logic [22:0] frac_f;
        fp_class_t   cls;
        exp_f  = word[30:23];
        frac_f = word[22:0];
        if (exp_f == 8'h00)
            cls = (frac_f == '0) ? CLS_ZERO : CLS_SUBNORMAL;
        else if (exp_f == EXP_ALL_ONES)
            cls = (frac_f == '0) ? CLS_INF : CLS_NAN;
        else
            cls = CLS_NORMAL;
        return cls;
    endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Synchronous-reset FIFO with occupancy output; head data is read
// combinationally from storage, so a written word appears one edge later.
module fpu_sync_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    output logic [W-1:0]     rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr;
    logic             rd;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign wr      = wr_en && !full;
    assign rd      = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr, rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fpu_mul_result_queue.sv
// Registered output queue behind the FP32 multiplier: buffers product words,
// tags each with its class, and keeps sticky exception status and a push count.
module fpu_mul_result_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_result,
    input  logic                         in_error,
    input  logic                         in_overflow,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_result,
    output logic                         out_error,
    output logic                         out_overflow,
    output logic [2:0]                   out_class,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         sticky_error,
    output logic                         sticky_overflow,
    output logic                         sticky_nan,
    input  logic                         sticky_clear,
    output logic [CNT_W-1:0]             op_count
);
    fp_result_t wr_word;
    fp_result_t head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wr_word.result   = in_result;
    assign wr_word.error    = in_error;
    assign wr_word.overflow = in_overflow;
    assign wr_word.cls      = fp_classify(in_result);

    fpu_sync_fifo #(
        .W     ($bits(fp_result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_word),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign out_result   = head.result;
    assign out_error    = head.error;
    assign out_overflow = head.overflow;
    assign out_class    = head.cls;

    // A setting push in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_error    <= 1'b0;
            sticky_overflow <= 1'b0;
            sticky_nan      <= 1'b0;
            op_count        <= '0;
        end else begin
            sticky_error    <= (sticky_error    && !sticky_clear) || (push && in_error);
            sticky_overflow <= (sticky_overflow && !sticky_clear) || (push && in_overflow);
            sticky_nan      <= (sticky_nan      && !sticky_clear) ||
                               (push && (wr_word.cls == CLS_NAN));
            if (push && (op_count != '1))
                op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fpu_mul_result_queue.sv
// Randomized and directed bench for fpu_mul_result_queue against a queue-based
// reference model; a second instance with CNT_W=2 exercises counter saturation.
module tb_fpu_mul_result_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_result = '0;
    logic        in_error = 1'b0;
    logic        in_overflow = 1'b0;
    logic        out_ready = 1'b0;
    logic        sticky_clear = 1'b0;

    logic        in_ready, out_valid, out_error, out_overflow;
    logic [31:0] out_result;
    logic [2:0]  out_class;
    logic [2:0]  level;
    logic        sticky_error, sticky_overflow, sticky_nan;
    logic [15:0] op_count;

    logic        in_ready2, out_valid2, out_error2, out_overflow2;
    logic [31:0] out_result2;
    logic [2:0]  out_class2;
    logic [2:0]  level2;
    logic        sticky_error2, sticky_overflow2, sticky_nan2;
    logic [1:0]  op_count2;

    always #5 clk = ~clk;

    fpu_mul_result_queue #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_error(in_error), .in_overflow(in_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_error(out_error), .out_overflow(out_overflow), .out_class(out_class),
        .level(level), .sticky_error(sticky_error), .sticky_overflow(sticky_overflow),
        .sticky_nan(sticky_nan), .sticky_clear(sticky_clear), .op_count(op_count)
    );

    fpu_mul_result_queue #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_result(in_result), .in_error(in_error), .in_overflow(in_overflow),
        .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
        .out_error(out_error2), .out_overflow(out_overflow2), .out_class(out_class2),
        .level(level2), .sticky_error(sticky_error2), .sticky_overflow(sticky_overflow2),
        .sticky_nan(sticky_nan2), .sticky_clear(sticky_clear), .op_count(op_count2)
    );

    typedef struct {
        logic [31:0] r;
        logic        e;
        logic        o;
        int          c;
    } ent_t;

    ent_t q[$];
    int   m_count;
    int   m_err, m_ovf, m_nan;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_class(input logic [31:0] w);
        int e, f;
        e = int'((w >> 23) & 32'hFF);
        f = int'(w & 32'h7FFFFF);
        if (e == 0)   return (f == 0) ? 0 : 1;
        if (e == 255) return (f == 0) ? 3 : 4;
        return 2;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] s;
        logic [31:0] f;
        logic [31:0] e;
        s = $urandom_range(0, 1) << 31;
        f = $urandom & 32'h7FFFFF;
        case ($urandom_range(0, 5))
            0: return s;
            1: return s | (f == 0 ? 32'd1 : f);
            2: return s | 32'h7F800000;
            3: return s | 32'h7F800000 | (f == 0 ? 32'd5 : f);
            default: begin
                e = $urandom_range(1, 254);
                return s | (e << 23) | f;
            end
        endcase
    endfunction

    task automatic check_all();
        chk("in_ready", in_ready, q.size() != DEPTH);
        chk("out_valid", out_valid, q.size() != 0);
        chk("level", level, q.size());
        chk("level_dut2", level2, q.size());
        if (q.size() != 0) begin
            chk("out_result", out_result, q[0].r);
            chk("out_error", out_error, q[0].e);
            chk("out_overflow", out_overflow, q[0].o);
            chk("out_class", out_class, q[0].c);
        end
        chk("op_count", op_count, m_count > 65535 ? 65535 : m_count);
        chk("op_count_sat", op_count2, m_count > 3 ? 3 : m_count);
        chk("sticky_error", sticky_error, m_err);
        chk("sticky_overflow", sticky_overflow, m_ovf);
        chk("sticky_nan", sticky_nan, m_nan);
    endtask

    // Called at a negedge: drive, let one edge pass, update model, check at next negedge.
    task automatic cycle(input logic v, input logic rdy, input logic [31:0] w,
                         input logic err, input logic ovf, input logic clr);
        logic push, pop;
        ent_t n;
        in_valid = v; out_ready = rdy; in_result = w;
        in_error = err; in_overflow = ovf; sticky_clear = clr;
        push = v && (q.size() != DEPTH);
        pop  = rdy && (q.size() != 0);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) begin
            n.r = w; n.e = err; n.o = ovf; n.c = ref_class(w);
            q.push_back(n);
            m_count++;
        end
        m_err = (clr ? 0 : m_err) | (push && err);
        m_ovf = (clr ? 0 : m_ovf) | (push && ovf);
        m_nan = (clr ? 0 : m_nan) | (push && n.c == 4);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sticky_clear = 1'b0;
        @(posedge clk);
        q.delete(); m_count = 0; m_err = 0; m_ovf = 0; m_nan = 0;
        @(negedge clk);
        rst = 1'b0;
        check_all();
        chk("rst_out_result", out_result, 0);
        chk("rst_out_error", out_error, 0);
        chk("rst_out_overflow", out_overflow, 0);
        chk("rst_out_class", out_class, 0);
    endtask

    initial begin
        m_count = 0; m_err = 0; m_ovf = 0; m_nan = 0;
        @(negedge clk);
        do_reset();

        // Single word latency and pop
        cycle(1, 1, 32'h40C00000, 0, 0, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_result", out_result, 32'h40C00000);
        chk("t1_class", out_class, 2);
        chk("t1_level", level, 1);
        cycle(0, 1, 0, 0, 0, 0);
        chk("t1_level_after_pop", level, 0);
        chk("t1_op_count", op_count, 1);

        // Fill, reject fifth, drain in order
        cycle(1, 0, 32'h3F800000, 0, 0, 0);
        cycle(1, 0, 32'h00000000, 0, 0, 0);
        cycle(1, 0, 32'h00000001, 0, 0, 0);
        cycle(1, 0, 32'h7F800000, 0, 0, 0);
        chk("t2_in_ready_full", in_ready, 0);
        chk("t2_level_full", level, 4);
        cycle(1, 0, 32'h12345678, 0, 0, 0);
        chk("t2_level_reject", level, 4);
        chk("t2_count_reject", op_count, 5);
        chk("t2_c0", out_class, 2);
        cycle(0, 1, 0, 0, 0, 0);
        chk("t2_c1", out_class, 0);
        cycle(0, 1, 0, 0, 0, 0);
        chk("t2_c2", out_class, 1);
        cycle(0, 1, 0, 0, 0, 0);
        chk("t2_c3", out_class, 3);
        cycle(0, 1, 0, 0, 0, 0);

        // Full with simultaneous push and pop: pop only
        for (int i = 0; i < 4; i++) cycle(1, 0, 32'h40000000 + i, 0, 0, 0);
        cycle(1, 1, 32'h41000000, 0, 0, 0);
        chk("t3_level_pop_only", level, 3);
        cycle(1, 0, 32'h41000000, 0, 0, 0);
        chk("t3_level_refill", level, 4);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0);

        // Sticky flags
        cycle(1, 1, 32'h7FC00000, 1, 0, 0);
        cycle(1, 1, 32'h7F800000, 0, 1, 0);
        chk("t4_nan", sticky_nan, 1);
        chk("t4_err", sticky_error, 1);
        chk("t4_ovf", sticky_overflow, 1);
        cycle(0, 1, 0, 0, 0, 1);
        chk("t4_clr_err", sticky_error, 0);
        chk("t4_clr_ovf", sticky_overflow, 0);
        chk("t4_clr_nan", sticky_nan, 0);
        cycle(1, 1, 32'h3F800000, 1, 0, 1);
        chk("t4_set_wins", sticky_error, 1);
        cycle(0, 1, 0, 0, 0, 0);

        // Mid-operation reset
        for (int i = 0; i < 3; i++) cycle(1, 0, 32'h7FC00000 + i, 1, 1, 0);
        do_reset();
        chk("t5_level", level, 0);
        chk("t5_op_count", op_count, 0);
        chk("t5_sticky", {sticky_error, sticky_overflow, sticky_nan}, 0);

        // Counter saturation on the CNT_W=2 instance
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 32'h40400000, 0, 0, 0);
            chk("t6_cnt2", op_count2, (i + 1 > 3) ? 3 : i + 1);
        end
        for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rand_word(),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0);
            if (i == 300) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpu_mul_result_queue.md
Name: fpu_mul_result_queue

Overview:
- Registered output stage directly downstream of the combinational FP32 multiplier.
- Captures each product word (resultMul, errorMul, overflowMul) under a valid/ready handshake into a small FIFO.
- Classifies each product and accumulates sticky exception status.
- Presents results to the FPU writeback/consumer with backpressure, which decouples the multiplier from a stalling consumer.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  multiplier output word is valid this cycle.
- in_ready  out  1  queue can accept a word.
- in_result  in  32  IEEE-754 single product (from resultMul).
- in_error  in  1  errorMul.
- in_overflow  in  1  overflowMul.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry.
- out_result  out  32  head entry result.
- out_error  out  1  head entry error flag.
- out_overflow  out  1  head entry overflow flag.
- out_class  out  3  head entry class code (see package).
- level  out  $clog2(DEPTH+1)  current occupancy.
- sticky_error  out  1  OR of in_error over all accepted words since last clear.
- sticky_overflow  out  1  OR of in_overflow over all accepted words since last clear.
- sticky_nan  out  1  set when an accepted word classifies as NaN.
- sticky_clear  in  1  clears all sticky flags.
- op_count  out  CNT_W  accepted pushes; saturates at all-ones.

Behaviour:
- Reset (rst=1 at edge):
  - Pointers, level, op_count and all sticky flags go to 0.
  - Storage is zeroed.
  - After reset: out_valid=0, in_ready=1, and out_result/out_error/out_overflow/out_class all read 0.
  - Reset asserted mid-operation discards all queued entries; there is no drain.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- in_ready = (level != DEPTH).
  - Depends on registered state only; there is no combinational path from out_ready.
  - When full, a same-cycle pop does not enable a push.
- out_valid = (level != 0).
  - out_* fields are read combinationally from the head entry.
  - There is no fall-through: a word pushed at edge N is visible on out_* after edge N.
  - Minimum latency is 1 cycle.
- Level update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together (not full, not empty): unchanged, with the head advancing and the new word written at the tail.
- Pointers wrap modulo DEPTH.
  - Order is strictly FIFO.
  - Held head fields must stay stable while out_valid=1 and out_ready=0.
- Classification is computed on the pushed word and stored with it:
  - exp=0 and frac=0 -> ZERO.
  - exp=0 and frac!=0 -> SUBNORMAL.
  - exp=FF and frac=0 -> INF.
  - exp=FF and frac!=0 -> NAN.
  - otherwise -> NORMAL.
- Sticky flags:
  - A flag is set on a push whose flag or class applies.
  - sticky_clear zeroes them at the edge.
  - If sticky_clear coincides with a setting push, set wins (flag = 1 after the edge).
  - Flags are unaffected by pops.
- op_count increments on each push and holds at 2^CNT_W-1 (no wrap).
- in_valid while full: the word is not accepted. The upstream must hold it; this stage drops nothing silently.

Decomposition:
- Shared package fpu_pkg holds:
  - Class codes: ZERO=3'd0, SUBNORMAL=3'd1, NORMAL=3'd2, INF=3'd3, NAN=3'd4.
  - Constants EXP_ALL_ONES=8'hFF and QNAN_DEFAULT=32'h7FC00000.
  - A packed struct fp_result_t {result[31:0], error, overflow, cls[2:0]}.
  - A function fp_classify(word) -> class, for reuse by the adder/divider output stages.
- One sub-module, fpu_sync_fifo (parameterised width/depth, synchronous-reset FIFO with level output), is natural.
- The top instantiates fpu_sync_fifo and adds classification, sticky flags and the counter.

Test Plan:
- Reset, then push 0x40C00000 (6.0), out_ready=1 -> next cycle out_valid=1, out_result=0x40C00000, out_class=NORMAL, level=1; after pop, level=0, op_count=1.
- out_ready=0, push 4 words 0x3F800000, 0x00000000, 0x00000001, 0x7F800000 -> in_ready=0 after 4th, level=4; a 5th in_valid is not accepted. Then out_ready=1 -> pops in order with classes NORMAL, ZERO, SUBNORMAL, INF.
- Full queue, in_valid=1 and out_ready=1 same cycle -> one pop, no push, level=3; next cycle the push is accepted, level=4.
- Push 0x7FC00000 with in_error=1, then word 0x7F800000 with in_overflow=1 -> sticky_nan=1, sticky_error=1, sticky_overflow=1. Then sticky_clear alone -> all 0. Then sticky_clear together with an in_error=1 push -> sticky_error=1.
- Push 3 words, assert rst for one cycle -> level=0, out_valid=0, in_ready=1, op_count=0, out_result=0, all sticky=0.
- CNT_W=2, push 5 words -> op_count reads 1, 2, 3, 3, 3.
